// File: rtl/seq_alu.sv
// Multicycle signed ALU: single-cycle logic/shift/add ops, radix-2 Booth multiply and
// non-restoring divide, with the 2*WIDTH result delivered into the C_hi/C_lo register pair.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A_reg,
  input  logic [WIDTH-1:0] B_reg,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] C_hi,
  output logic [WIDTH-1:0] C_lo,
  output logic             ovf,
  output logic             div0
);

  localparam int SAW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DFIX, S_DONE} state_e;

  state_e state, state_nx;

  logic [WIDTH-1:0]   sum, diff, neg_a, neg_b, a_mag, b_mag;
  logic [2*WIDTH-1:0] dbl, rot_r, rot_l;
  logic [SAW-1:0]     sh;
  logic [WIDTH-1:0]   alu_hi, alu_lo;
  logic               alu_ovf, alu_div0;
  logic               is_mul, is_div;

  // hi_r carries the Booth accumulator or the partial remainder, one guard bit wide
  logic [WIDTH:0]     hi_r, m_r, booth, rem_sh, rem_nx, rem_fix;
  logic [WIDTH-1:0]   lo_r;
  logic               q_1, neg_q, neg_r, flag_ovf, flag_div0;
  logic [SAW-1:0]     cnt;

  assign sum   = A_reg + B_reg;
  assign diff  = A_reg - B_reg;
  assign neg_a = '0 - A_reg;
  assign neg_b = '0 - B_reg;
  assign a_mag = A_reg[MSB] ? neg_a : A_reg;
  assign b_mag = B_reg[MSB] ? neg_b : B_reg;
  assign sh    = B_reg[SAW-1:0];
  assign dbl   = {A_reg, A_reg};
  assign rot_r = dbl >> sh;
  assign rot_l = dbl << sh;

  assign is_mul = (opcode == OP_MUL);
  assign is_div = (opcode == OP_DIV) && (B_reg != '0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    alu_hi   = '0;
    alu_lo   = '0;
    alu_ovf  = 1'b0;
    alu_div0 = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_lo  = sum;
        alu_ovf = (A_reg[MSB] == B_reg[MSB]) && (sum[MSB] != A_reg[MSB]);
      end
      OP_SUB: begin
        alu_lo  = diff;
        alu_ovf = (A_reg[MSB] != B_reg[MSB]) && (diff[MSB] != A_reg[MSB]);
      end
      OP_NEG: begin
        alu_lo  = neg_a;
        alu_ovf = A_reg[MSB] && (A_reg[MSB-1:0] == '0);
      end
      OP_AND:  alu_lo = A_reg & B_reg;
      OP_OR:   alu_lo = A_reg | B_reg;
      OP_NOT:  alu_lo = ~A_reg;
      OP_SHR:  alu_lo = A_reg >> sh;
      OP_SHRA: alu_lo = $signed(A_reg) >>> sh;
      OP_SHL:  alu_lo = A_reg << sh;
      OP_ROR:  alu_lo = rot_r[WIDTH-1:0];
      OP_ROL:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
      OP_DIV: begin
        if (B_reg == '0) begin
          alu_lo   = '1;
          alu_hi   = A_reg;
          alu_div0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case ({lo_r[0], q_1})
      2'b01:   booth = hi_r + m_r;
      2'b10:   booth = hi_r - m_r;
      default: booth = hi_r;
    endcase
  end

  // Non-restoring step on magnitudes: subtract while the remainder is non-negative, else add
  assign rem_sh  = {hi_r[WIDTH-1:0], lo_r[MSB]};
  assign rem_nx  = hi_r[WIDTH] ? (rem_sh + m_r) : (rem_sh - m_r);
  assign rem_fix = hi_r[WIDTH] ? (hi_r + m_r) : hi_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nx = is_mul ? S_MUL : (is_div ? S_DIV : S_DONE);
      end
      S_MUL:   if (cnt == '0) state_nx = S_DONE;
      S_DIV:   if (cnt == '0) state_nx = S_DFIX;
      S_DFIX:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: the working registers are reset along with the outputs, so an aborted op leaves
  // no stale partial product or remainder behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_r      <= '0;
      lo_r      <= '0;
      m_r       <= '0;
      q_1       <= 1'b0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      flag_ovf  <= 1'b0;
      flag_div0 <= 1'b0;
      done      <= 1'b0;
      C_hi      <= '0;
      C_lo      <= '0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt       <= SAW'(WIDTH - 1);
            q_1       <= 1'b0;
            flag_ovf  <= alu_ovf;
            flag_div0 <= alu_div0;
            neg_q     <= A_reg[MSB] ^ B_reg[MSB];
            neg_r     <= A_reg[MSB];
            if (is_mul) begin
              hi_r <= '0;
              lo_r <= B_reg;
              m_r  <= {A_reg[MSB], A_reg};
            end else if (is_div) begin
              hi_r <= '0;
              lo_r <= a_mag;
              m_r  <= {1'b0, b_mag};
            end else begin
              hi_r <= {1'b0, alu_hi};
              lo_r <= alu_lo;
            end
          end
        end
        S_MUL: begin
          hi_r <= {booth[WIDTH], booth[WIDTH:1]};
          lo_r <= {booth[0], lo_r[MSB:1]};
          q_1  <= lo_r[0];
          cnt  <= cnt - SAW'(1);
        end
        S_DIV: begin
          hi_r <= rem_nx;
          lo_r <= {lo_r[MSB-1:0], ~rem_nx[WIDTH]};
          cnt  <= cnt - SAW'(1);
        end
        S_DFIX: begin
          hi_r <= neg_r ? ('0 - rem_fix) : rem_fix;
          lo_r <= neg_q ? ('0 - lo_r) : lo_r;
        end
        S_DONE: begin
          C_hi <= hi_r[WIDTH-1:0];
          C_lo <= lo_r;
          ovf  <= flag_ovf;
          div0 <= flag_div0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed corner cases, busy/abort behaviour
// and a random mix, with expected results queued at issue and matched on each done pulse.
module tb_seq_alu;

  localparam int W = 32;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BAD  = 5'b11111;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    logic        div0;
    int          lat;
    int          accept;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [4:0]    opcode;
  logic [W-1:0]  A_reg, B_reg;
  logic          ready, done, ovf, div0;
  logic [W-1:0]  C_hi, C_lo;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .opcode (opcode),
    .A_reg  (A_reg),
    .B_reg  (B_reg),
    .ready  (ready),
    .done   (done),
    .C_hi   (C_hi),
    .C_lo   (C_lo),
    .ovf    (ovf),
    .div0   (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, want);
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, r;
    logic [63:0] p;
    logic [31:0] t;
    int          sh;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sh  = int'(b[4:0]);
    e.tag = $sformatf("op%05b a=%h b=%h", op, a, b);
    e.hi = '0; e.lo = '0; e.ovf = 1'b0; e.div0 = 1'b0; e.lat = 1; e.accept = 0;
    t = a;
    case (op)
      OP_ADD: begin r = sa + sbv; e.lo = r[31:0]; e.ovf = (r > MAXS) || (r < MINS); end
      OP_SUB: begin r = sa - sbv; e.lo = r[31:0]; e.ovf = (r > MAXS) || (r < MINS); end
      OP_NEG: begin r = -sa;      e.lo = r[31:0]; e.ovf = (r > MAXS); end
      OP_AND:  e.lo = a & b;
      OP_OR:   e.lo = a | b;
      OP_NOT:  e.lo = ~a;
      OP_SHR:  e.lo = a >> sh;
      OP_SHRA: e.lo = $signed(a) >>> sh;
      OP_SHL:  e.lo = a << sh;
      OP_ROR: begin for (int i = 0; i < sh; i++) t = {t[0], t[31:1]}; e.lo = t; end
      OP_ROL: begin for (int i = 0; i < sh; i++) t = {t[30:0], t[31]}; e.lo = t; end
      OP_MUL: begin
        r = sa * sbv; p = r;
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = W + 1;
      end
      OP_DIV: begin
        if (b == '0) begin
          e.div0 = 1'b1; e.lo = '1; e.hi = a;
        end else begin
          r = sa / sbv; e.lo = r[31:0];
          r = sa % sbv; e.hi = r[31:0];
          e.lat = W + 2;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s latency", e.tag), 64'(cyc - e.accept), 64'(e.lat));
        check($sformatf("%s C_hi", e.tag), C_hi, e.hi);
        check($sformatf("%s C_lo", e.tag), C_lo, e.lo);
        check($sformatf("%s ovf", e.tag), ovf, e.ovf);
        check($sformatf("%s div0", e.tag), div0, e.div0);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    @(negedge clk);
    t = 0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_wait", ready, 1'b1);
    start = 1'b1; opcode = op; A_reg = a; B_reg = b;
    e = model(op, a, b);
    @(posedge clk);
    #1;
    e.accept = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; A_reg = $urandom(); B_reg = $urandom(); opcode = 5'($urandom());
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  initial begin
    logic [4:0] ops [14];
    int         nd;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_BAD};
    reset_n = 1'b0; start = 1'b0; opcode = '0; A_reg = '0; B_reg = '0;
    repeat (3) @(negedge clk);
    check("rst ready", ready, 1'b1);
    check("rst done",  done,  1'b0);
    check("rst C_hi",  C_hi,  '0);
    check("rst C_lo",  C_lo,  '0);
    check("rst ovf",   ovf,   1'b0);
    check("rst div0",  div0,  1'b0);
    reset_n = 1'b1;

    issue(OP_ADD,  32'd5,        32'd7);
    issue(OP_ADD,  32'h7FFFFFFF, 32'd1);
    issue(OP_SUB,  32'h80000000, 32'd1);
    issue(OP_SUB,  32'd3,        32'd10);
    issue(OP_NEG,  32'h80000000, 32'd0);
    issue(OP_NEG,  32'd5,        32'd0);
    issue(OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0);
    issue(OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0);
    issue(OP_NOT,  32'h12345678, 32'd0);
    issue(OP_SHR,  32'h80000000, 32'd0);
    issue(OP_SHR,  32'h80000000, 32'd4);
    issue(OP_SHRA, 32'h80000000, 32'd31);
    issue(OP_SHL,  32'h00000003, 32'hFFFFFFE4);
    issue(OP_ROR,  32'h80000001, 32'd1);
    issue(OP_ROL,  32'h80000001, 32'd4);
    issue(OP_BAD,  32'h12345678, 32'h9ABCDEF0);
    issue(5'b00000, 32'd1,       32'd1);
    wait_idle();

    issue(OP_MUL, 32'hFFFFFFF9, 32'd6);
    repeat (3) begin
      @(negedge clk);
      check("busy ready", ready, 1'b0);
      start = 1'b1; opcode = OP_ADD; A_reg = 32'd1; B_reg = 32'd1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    issue(OP_MUL, 32'h80000000, 32'h80000000);
    issue(OP_MUL, 32'h7FFFFFFF, 32'h80000000);
    issue(OP_DIV, 32'hFFFFFFEF, 32'd5);
    issue(OP_DIV, 32'd17,       32'hFFFFFFFB);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    issue(OP_DIV, 32'd3,        32'd7);
    issue(OP_DIV, 32'd9,        32'd0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold C_lo", C_lo, 32'hFFFFFFFF);
    check("hold C_hi", C_hi, 32'd9);
    check("hold div0", div0, 1'b1);

    issue(OP_ADD, 32'd100, 32'd23);
    wait_idle();
    issue(OP_MUL, 32'd12345, 32'd678);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort ready", ready, 1'b1);
    check("abort done",  done,  1'b0);
    check("abort C_lo",  C_lo,  '0);
    check("abort C_hi",  C_hi,  '0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort no done", 64'(nd), 64'd0);
    issue(OP_ADD, 32'd40, 32'd2);
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 13)];
      a  = pick();
      b  = (op == OP_DIV && $urandom_range(0, 5) == 0) ? 32'd0 : pick();
      issue(op, a, b);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
